// File: rtl/sap1_pkg.sv
// sap1_pkg
// Shared definitions for the SAP-1 datapath and its microcoded control unit:
// control-word bit positions, a packed view of the control word, the NOP
// word and the instruction opcodes.
// Ports: none (package).
package sap1_pkg;

  // Bit positions inside the 12-bit control word, MSB first.
  localparam int CW_PC_EN  = 11;
  localparam int CW_PC_INC = 10;
  localparam int CW_MAR_LD = 9;
  localparam int CW_IR_EN  = 8;
  localparam int CW_IR_LD  = 7;
  localparam int CW_MEM_EN = 6;
  localparam int CW_A_EN   = 5;
  localparam int CW_A_LD   = 4;
  localparam int CW_B_LD   = 3;
  localparam int CW_ALU_EN = 2;
  localparam int CW_O_LD   = 1;
  localparam int CW_SUB    = 0;

  localparam logic [11:0] CW_NOP = 12'h000;

  // Opcodes carried in ir[7:4].
  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;

  // Field order matches the bit positions above so a plain cast works.
  typedef struct packed {
    logic pc_en;
    logic pc_inc;
    logic mar_ld;
    logic ir_en;
    logic ir_ld;
    logic mem_en;
    logic a_en;
    logic a_ld;
    logic b_ld;
    logic alu_en;
    logic o_ld;
    logic sub;
  } cword_t;

  function automatic cword_t decode_cword(input logic [11:0] raw);
    return cword_t'(raw);
  endfunction

endpackage

// File: rtl/sap1_ram16x8.sv
// sap1_ram16x8
// 16x8 program/data memory. Reads are asynchronous so the bus sees the word
// at mar in the same cycle; writes come from the program-load port on any
// clock edge. Contents are deliberately not reset.
// Ports:
//   clk    in   write clock
//   we     in   write strobe
//   waddr  in   4-bit write address
//   wdata  in   8-bit write data
//   raddr  in   4-bit asynchronous read address
//   rdata  out  8-bit read data
module sap1_ram16x8 (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read: a write to the same address only becomes visible after
  // the edge, which gives read-before-write behaviour for free.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// sap1_datapath
// SAP-1 datapath built around a single 8-bit W-bus. Each clken-qualified
// cycle the control word selects one (normally) bus driver and any number of
// loads. The instruction register is returned to the control unit for decode.
// Ports:
//   sysclk     in   system clock, rising edge
//   clear_n    in   asynchronous active-low reset
//   clken      in   datapath clock enable
//   cword      in   12-bit control word (PC_EN..SUB, MSB first)
//   prog_we    in   RAM program-write strobe (ignores clken)
//   prog_addr  in   RAM program-write address
//   prog_data  in   RAM program-write data
//   ir         out  instruction register
//   out_reg    out  output register
//   bus        out  current W-bus value
//   carry      out  ALU carry / no-borrow flag
//   zero       out  ALU zero flag
//   bus_err    out  sticky multiple-driver flag
import sap1_pkg::*;

module sap1_datapath (
  input  logic        sysclk,
  input  logic        clear_n,
  input  logic        clken,
  input  logic [11:0] cword,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [7:0]  ir,
  output logic [7:0]  out_reg,
  output logic [7:0]  bus,
  output logic        carry,
  output logic        zero,
  output logic        bus_err
);

  cword_t     cw;
  logic [3:0] pc;
  logic [3:0] mar;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] ram_data;
  logic [8:0] alu_sum;
  logic [7:0] alu_result;
  logic [4:0] drv_en;
  logic       conflict;

  assign cw = decode_cword(cword);

  sap1_ram16x8 u_ram (
    .clk   (sysclk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (mar),
    .rdata (ram_data)
  );

  // Subtraction is two's complement add; bit 8 is then the no-borrow flag.
  always_comb begin
    if (cw.sub) begin
      alu_sum = {1'b0, a_reg} + {1'b0, ~b_reg} + 9'd1;
    end else begin
      alu_sum = {1'b0, a_reg} + {1'b0, b_reg};
    end
  end

  assign alu_result = alu_sum[7:0];

  // Drivers are OR-ed so a conflict is visible on the bus instead of hiding
  // behind a priority order.
  always_comb begin
    bus = 8'h00;
    if (cw.pc_en)  bus = bus | {4'h0, pc};
    if (cw.ir_en)  bus = bus | {4'h0, ir[3:0]};
    if (cw.mem_en) bus = bus | ram_data;
    if (cw.a_en)   bus = bus | a_reg;
    if (cw.alu_en) bus = bus | alu_result;
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign drv_en   = {cw.pc_en, cw.ir_en, cw.mem_en, cw.a_en, cw.alu_en};
  assign conflict = |(drv_en & (drv_en - 5'd1));

  always_ff @(posedge sysclk or negedge clear_n) begin
    if (!clear_n) begin
      pc      <= 4'h0;
      mar     <= 4'h0;
      ir      <= 8'h00;
      a_reg   <= 8'h00;
      b_reg   <= 8'h00;
      out_reg <= 8'h00;
      carry   <= 1'b0;
      zero    <= 1'b0;
      bus_err <= 1'b0;
    end else if (clken) begin
      if (cw.pc_inc) pc      <= pc + 4'd1;
      if (cw.mar_ld) mar     <= bus[3:0];
      if (cw.ir_ld)  ir      <= bus;
      if (cw.a_ld)   a_reg   <= bus;
      if (cw.b_ld)   b_reg   <= bus;
      if (cw.o_ld)   out_reg <= bus;
      // Flags only track an ALU result that is actually written back to A.
      if (cw.alu_en && cw.a_ld) begin
        carry <= alu_sum[8];
        zero  <= (alu_result == 8'h00);
      end
      if (conflict) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sap1_datapath.sv
// tb_sap1_datapath
// Directed SAP-1 microstep sequences followed by randomized control words,
// all compared against a behavioural model of the datapath.
import sap1_pkg::*;

module tb_sap1_datapath;

  logic        sysclk;
  logic        clear_n;
  logic        clken;
  logic [11:0] cword;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [7:0]  ir;
  logic [7:0]  out_reg;
  logic [7:0]  bus;
  logic        carry;
  logic        zero;
  logic        bus_err;

  int assertCount;
  int failCount;

  // Behavioural model state
  logic [3:0] mPc;
  logic [3:0] mMar;
  logic [7:0] mIr;
  logic [7:0] mA;
  logic [7:0] mB;
  logic [7:0] mOut;
  logic       mCarry;
  logic       mZero;
  logic       mErr;
  logic [7:0] mRam [16];

  localparam logic [11:0] M_PC_EN  = 12'h800;
  localparam logic [11:0] M_PC_INC = 12'h400;
  localparam logic [11:0] M_MAR_LD = 12'h200;
  localparam logic [11:0] M_IR_EN  = 12'h100;
  localparam logic [11:0] M_IR_LD  = 12'h080;
  localparam logic [11:0] M_MEM_EN = 12'h040;
  localparam logic [11:0] M_A_EN   = 12'h020;
  localparam logic [11:0] M_A_LD   = 12'h010;
  localparam logic [11:0] M_B_LD   = 12'h008;
  localparam logic [11:0] M_ALU_EN = 12'h004;
  localparam logic [11:0] M_O_LD   = 12'h002;
  localparam logic [11:0] M_SUB    = 12'h001;

  sap1_datapath dut (
    .sysclk    (sysclk),
    .clear_n   (clear_n),
    .clken     (clken),
    .cword     (cword),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ir        (ir),
    .out_reg   (out_reg),
    .bus       (bus),
    .carry     (carry),
    .zero      (zero),
    .bus_err   (bus_err)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ALU from plain unsigned arithmetic: {carry, result}
  function automatic logic [8:0] modelAlu(input logic sub);
    int ia;
    int ib;
    int s;
    logic [7:0] r;
    logic c;
    ia = int'(mA);
    ib = int'(mB);
    if (sub) begin
      c = (ia >= ib);
      r = 8'((ia - ib) & 255);
    end else begin
      s = ia + ib;
      c = (s > 255);
      r = 8'(s % 256);
    end
    return {c, r};
  endfunction

  function automatic logic [7:0] modelBus(input logic [11:0] c);
    logic [7:0] v;
    logic [8:0] alu;
    v = 8'h00;
    alu = modelAlu(c[CW_SUB]);
    if (c[CW_PC_EN])  v = v | {4'h0, mPc};
    if (c[CW_IR_EN])  v = v | {4'h0, mIr[3:0]};
    if (c[CW_MEM_EN]) v = v | mRam[mMar];
    if (c[CW_A_EN])   v = v | mA;
    if (c[CW_ALU_EN]) v = v | alu[7:0];
    return v;
  endfunction

  function automatic int driverCount(input logic [11:0] c);
    return int'(c[CW_PC_EN]) + int'(c[CW_IR_EN]) + int'(c[CW_MEM_EN]) +
           int'(c[CW_A_EN]) + int'(c[CW_ALU_EN]);
  endfunction

  task automatic modelEdge(input logic [11:0] c, input logic en, input logic pwe,
                           input logic [3:0] paddr, input logic [7:0] pdata);
    logic [7:0] b;
    logic [8:0] alu;
    b = modelBus(c);
    alu = modelAlu(c[CW_SUB]);
    if (en) begin
      if (c[CW_PC_INC]) mPc = 4'((int'(mPc) + 1) % 16);
      if (c[CW_MAR_LD]) mMar = b[3:0];
      if (c[CW_IR_LD])  mIr = b;
      if (c[CW_A_LD])   mA = b;
      if (c[CW_B_LD])   mB = b;
      if (c[CW_O_LD])   mOut = b;
      if (c[CW_ALU_EN] && c[CW_A_LD]) begin
        mCarry = alu[8];
        mZero  = (alu[7:0] == 8'h00);
      end
      if (driverCount(c) > 1) mErr = 1'b1;
    end
    if (pwe) mRam[paddr] = pdata;
  endtask

  task automatic modelReset();
    mPc = 4'h0; mMar = 4'h0; mIr = 8'h00; mA = 8'h00; mB = 8'h00;
    mOut = 8'h00; mCarry = 1'b0; mZero = 1'b0; mErr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Observe an internal register through the bus without clocking anything.
  task automatic peek(input logic [11:0] c, output logic [7:0] val);
    cword = c;
    clken = 1'b0;
    #1;
    val = bus;
    cword = CW_NOP;
  endtask

  task automatic checkState();
    logic [7:0] v;
    checkOutput("ir", ir, mIr);
    checkOutput("out_reg", out_reg, mOut);
    checkOutput("carry", {7'h0, carry}, {7'h0, mCarry});
    checkOutput("zero", {7'h0, zero}, {7'h0, mZero});
    checkOutput("bus_err", {7'h0, bus_err}, {7'h0, mErr});
    peek(M_A_EN, v);
    checkOutput("a_via_bus", v, mA);
    peek(M_PC_EN, v);
    checkOutput("pc_via_bus", v, {4'h0, mPc});
  endtask

  task automatic applyStimulus(input logic [11:0] c, input logic en, input logic pwe,
                               input logic [3:0] paddr, input logic [7:0] pdata);
    @(negedge sysclk);
    cword = c;
    clken = en;
    prog_we = pwe;
    prog_addr = paddr;
    prog_data = pdata;
    #1;
    checkOutput("bus", bus, modelBus(c));
    @(posedge sysclk);
    #1;
    modelEdge(c, en, pwe, paddr, pdata);
    cword = CW_NOP;
    clken = 1'b0;
    prog_we = 1'b0;
    checkState();
  endtask

  task automatic step(input logic [11:0] c);
    applyStimulus(c, 1'b1, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic progWrite(input logic [3:0] addr, input logic [7:0] data);
    applyStimulus(CW_NOP, 1'b0, 1'b1, addr, data);
  endtask

  task automatic doReset();
    logic [7:0] v;
    clear_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_ir", ir, 8'h00);
    checkOutput("rst_out", out_reg, 8'h00);
    checkOutput("rst_carry", {7'h0, carry}, 8'h00);
    checkOutput("rst_zero", {7'h0, zero}, 8'h00);
    checkOutput("rst_bus_err", {7'h0, bus_err}, 8'h00);
    peek(M_A_EN, v);
    checkOutput("rst_a", v, 8'h00);
    peek(M_PC_EN, v);
    checkOutput("rst_pc", v, 8'h00);
    clear_n = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    logic [11:0] c;
    logic en;
    logic pwe;
    int d;

    assertCount = 0;
    failCount = 0;
    clear_n = 1'b0;
    clken = 1'b0;
    cword = CW_NOP;
    prog_we = 1'b0;
    prog_addr = 4'h0;
    prog_data = 8'h00;
    modelReset();
    for (int i = 0; i < 16; i++) mRam[i] = 8'h00;

    #12;
    checkOutput("init_ir", ir, 8'h00);
    checkOutput("init_out", out_reg, 8'h00);
    checkOutput("init_bus_err", {7'h0, bus_err}, 8'h00);
    clear_n = 1'b1;

    // Fill RAM with known random content
    for (int i = 0; i < 16; i++) progWrite(4'(i), 8'($urandom_range(0, 255)));

    // Reset mid-cycle: A=55, PC=3, RAM[0]=A7 survives
    progWrite(4'h0, 8'h55);
    step(M_MEM_EN | M_A_LD);
    step(M_PC_INC);
    step(M_PC_INC);
    step(M_PC_INC);
    progWrite(4'h0, 8'hA7);
    peek(M_A_EN, v);
    checkOutput("pre_rst_a", v, 8'h55);
    peek(M_PC_EN, v);
    checkOutput("pre_rst_pc", v, 8'h03);
    doReset();
    peek(M_MEM_EN, v);
    checkOutput("ram_kept", v, 8'hA7);

    // Fetch
    progWrite(4'h0, 8'h09);
    step(M_PC_EN | M_MAR_LD);
    step(M_PC_INC);
    step(M_MEM_EN | M_IR_LD);
    checkOutput("fetch_ir", ir, 8'h09);
    peek(M_PC_EN, v);
    checkOutput("fetch_pc", v, 8'h01);
    peek(M_MEM_EN, v);
    checkOutput("fetch_mar0", v, 8'h09);

    // LDA 9 ; ADD 10 ; OUT
    progWrite(4'd9, 8'hF0);
    progWrite(4'd10, 8'h20);
    progWrite(4'd1, {ADD, 4'hA});
    step(M_IR_EN | M_MAR_LD);
    step(M_MEM_EN | M_A_LD);
    peek(M_A_EN, v);
    checkOutput("lda_a", v, 8'hF0);
    step(M_PC_EN | M_MAR_LD);
    step(M_PC_INC);
    step(M_MEM_EN | M_IR_LD);
    checkOutput("add_ir", ir, 8'h1A);
    step(M_IR_EN | M_MAR_LD);
    step(M_MEM_EN | M_B_LD);
    step(M_ALU_EN | M_A_LD);
    peek(M_A_EN, v);
    checkOutput("add_a", v, 8'h10);
    checkOutput("add_carry", {7'h0, carry}, 8'h01);
    checkOutput("add_zero", {7'h0, zero}, 8'h00);
    step(M_A_EN | M_O_LD);
    checkOutput("out_reg", out_reg, 8'h10);

    // Subtract to zero, then with borrow (mar is 10)
    step(M_MEM_EN | M_A_LD | M_B_LD);
    step(M_SUB | M_ALU_EN | M_A_LD);
    peek(M_A_EN, v);
    checkOutput("sub0_a", v, 8'h00);
    checkOutput("sub0_zero", {7'h0, zero}, 8'h01);
    checkOutput("sub0_carry", {7'h0, carry}, 8'h01);
    progWrite(4'd10, 8'h10);
    step(M_MEM_EN | M_A_LD);
    step(M_SUB | M_ALU_EN | M_A_LD);
    peek(M_A_EN, v);
    checkOutput("subb_a", v, 8'hF0);
    checkOutput("subb_carry", {7'h0, carry}, 8'h00);
    checkOutput("subb_zero", {7'h0, zero}, 8'h00);
    step(M_SUB);
    step(M_ALU_EN);

    // Read-before-write on the same RAM address
    step(M_MEM_EN | M_A_LD);
    applyStimulus(M_MEM_EN | M_A_LD, 1'b1, 1'b1, 4'd10, 8'h77);
    peek(M_A_EN, v);
    checkOutput("rbw_a_old", v, 8'h10);
    peek(M_MEM_EN, v);
    checkOutput("rbw_ram_new", v, 8'h77);

    // PC wrap
    doReset();
    for (int i = 0; i < 16; i++) step(M_PC_INC);
    peek(M_PC_EN, v);
    checkOutput("pc_wrap", v, 8'h00);

    // Clock-enable gating
    progWrite(4'h0, 8'h5A);
    step(M_MEM_EN | M_A_LD);
    progWrite(4'h0, 8'h33);
    applyStimulus(M_MEM_EN | M_A_LD | M_PC_INC, 1'b0, 1'b0, 4'h0, 8'h00);
    peek(M_A_EN, v);
    checkOutput("gated_a", v, 8'h5A);
    peek(M_PC_EN, v);
    checkOutput("gated_pc", v, 8'h00);

    // Bus conflict
    doReset();
    progWrite(4'h0, 8'h0C);
    step(M_MEM_EN | M_A_LD);
    step(M_PC_INC);
    step(M_PC_INC);
    step(M_PC_INC);
    peek(M_PC_EN | M_A_EN, v);
    checkOutput("conflict_bus", v, 8'h0F);
    checkOutput("conflict_err_before", {7'h0, bus_err}, 8'h00);
    step(M_PC_EN | M_A_EN);
    checkOutput("conflict_err", {7'h0, bus_err}, 8'h01);
    step(CW_NOP);
    step(M_A_EN | M_B_LD);
    checkOutput("conflict_err_held", {7'h0, bus_err}, 8'h01);
    doReset();

    // Randomized control words
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      c = CW_NOP;
      c[CW_PC_INC] = 1'($urandom_range(0, 1));
      c[CW_MAR_LD] = 1'($urandom_range(0, 1));
      c[CW_IR_LD]  = 1'($urandom_range(0, 1));
      c[CW_A_LD]   = 1'($urandom_range(0, 1));
      c[CW_B_LD]   = 1'($urandom_range(0, 1));
      c[CW_O_LD]   = 1'($urandom_range(0, 1));
      c[CW_SUB]    = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, 5));
      case (d)
        0: c[CW_PC_EN] = 1'b1;
        1: c[CW_IR_EN] = 1'b1;
        2: c[CW_MEM_EN] = 1'b1;
        3: c[CW_A_EN] = 1'b1;
        4: c[CW_ALU_EN] = 1'b1;
        default: ;
      endcase
      if ($urandom_range(0, 31) == 0) c[CW_A_EN] = 1'b1;
      en = ($urandom_range(0, 3) != 0);
      pwe = ($urandom_range(0, 3) == 0);
      applyStimulus(c, en, pwe, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
